frame_stream_ctrl: RTL

- Hardware initiator for the imageprocessor load/readout protocol. Replaces the file-driven stimulus with on-chip memories.
- Streams one frame from a source frame RAM into imageprocessor during the load phase (dlay=1).
- Then switches to the readout phase (dlay=0) and writes each dou pixel into a destination frame RAM in raster order.
- Sits between the frame buffers and imageprocessor; sequenced by a single start/done handshake.

---
 rtl/frame_stream_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/frame_stream_ctrl.sv
// Frame initiator for imageprocessor: streams a source frame in (dlay=1),
// then captures the processed readout into a destination frame RAM (dlay=0).
module frame_stream_ctrl #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int DW     = 8,
  parameter int AW     = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          src_rd,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  output logic          dlay,
  output logic [DW-1:0] din,
  output logic          din_vld,
  input  logic [DW-1:0] dou,
  output logic          dst_we,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, READOUT, WRITE_LAST} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] src_addr_q;
  logic [AW-1:0] pix;
  logic          rd_q;
  logic          last;
  logic          accept;

  assign last     = (col == CW'(WIDTH - 1)) && (row == RW'(HEIGHT - 1));
  assign accept   = (state == IDLE) && start;
  assign busy     = (state != IDLE);
  assign src_rd   = (state == LOAD);
  assign src_addr = src_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = LOAD;
      LOAD:       if (last)  state_nxt = FLUSH;
      FLUSH:      state_nxt = READOUT;
      READOUT:    if (last)  state_nxt = WRITE_LAST;
      WRITE_LAST: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Raster counters shared by both phases; address counters avoid a row*WIDTH multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      src_addr_q <= '0;
      pix        <= '0;
    end else begin
      if (accept || state == FLUSH) begin
        col <= '0;
        row <= '0;
      end else if (state == LOAD || state == READOUT) begin
        if (last) begin
          col <= '0;
          row <= '0;
        end else if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept)                      src_addr_q <= '0;
      else if (state == LOAD && !last) src_addr_q <= src_addr_q + 1'b1;
      if (state == FLUSH)                 pix <= '0;
      else if (state == READOUT && !last) pix <= pix + 1'b1;
    end
  end

  // dlay is registered off the state so it drops one cycle into READOUT,
  // right after the last din beat drains out of the read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= 1'b0;
      din_vld  <= 1'b0;
      din      <= '0;
      dlay     <= 1'b1;
      dst_we   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
      done     <= 1'b0;
    end else begin
      rd_q    <= src_rd;
      din_vld <= rd_q;
      if (rd_q) din <= src_data;
      dlay    <= (state != READOUT);
      dst_we  <= (state == READOUT);
      if (state == READOUT) begin
        dst_addr <= pix;
        dst_data <= dou;
      end
      done    <= (state == WRITE_LAST);
    end
  end

endmodule
